// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit single-cycle core: condition codes,
// flag bit positions, reset PC and the PC-stage state encoding.
package cpu_pkg;

    localparam logic [2:0] COND_NE  = 3'b000;
    localparam logic [2:0] COND_EQ  = 3'b001;
    localparam logic [2:0] COND_GT  = 3'b010;
    localparam logic [2:0] COND_LT  = 3'b011;
    localparam logic [2:0] COND_GE  = 3'b100;
    localparam logic [2:0] COND_LE  = 3'b101;
    localparam logic [2:0] COND_OV  = 3'b110;
    localparam logic [2:0] COND_UNC = 3'b111;

    localparam int FLAG_Z = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_N = 0;

    localparam logic [15:0] DEFAULT_RESET_PC = 16'h0000;

    typedef enum logic [0:0] {
        RUN    = 1'b0,
        HALTED = 1'b1
    } state_e;

endpackage

// File: rtl/cond_eval.sv
// Combinational branch-condition evaluator: decides whether cond holds
// for a given {Z,V,N} flag vector.
module cond_eval
    import cpu_pkg::*;
(
    input  logic [2:0] cond,
    input  logic [2:0] flags,
    output logic       cond_true
);

    logic z;
    logic v;
    logic n;

    assign z = flags[FLAG_Z];
    assign v = flags[FLAG_V];
    assign n = flags[FLAG_N];

    // NOTE: a default assignment ahead of the case keeps every path driven,
    // so no latch is inferred for cond_true.
    always_comb begin
        cond_true = 1'b0;
        case (cond)
            COND_NE:  cond_true = !z;
            COND_EQ:  cond_true = z;
            COND_GT:  cond_true = !z && !n;
            COND_LT:  cond_true = n;
            COND_GE:  cond_true = z || (!z && !n);
            COND_LE:  cond_true = n || z;
            COND_OV:  cond_true = v;
            COND_UNC: cond_true = 1'b1;
            default:  cond_true = 1'b0;
        endcase
    end

endmodule

// File: rtl/pc_control.sv
// PC and branch-resolution stage: holds PC and {Z,V,N}, resolves B/BR,
// sequences HLT and counts retired instructions.
module pc_control
    import cpu_pkg::*;
#(
    parameter logic [15:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             branch,
    input  logic             branch_reg,
    input  logic             hlt,
    input  logic [2:0]       cond,
    input  logic [8:0]       br_offset,
    input  logic [15:0]      br_target,
    input  logic [2:0]       flag_en,
    input  logic [2:0]       flag_in,
    output logic [15:0]      pc,
    output logic [15:0]      pc_plus2,
    output logic [2:0]       flags,
    output logic             taken,
    output logic             halted,
    output logic [CNT_W-1:0] instr_count
);

    state_e           state_q, state_d;
    logic [15:0]      pc_q, pc_d;
    logic [2:0]       flags_q, flags_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic        cond_true;
    logic [15:0] br_disp;
    logic [15:0] next_pc;

    cond_eval u_cond_eval (
        .cond      (cond),
        .flags     (flags_q),
        .cond_true (cond_true)
    );

    // The condition sees the registered flags, so a same-cycle flag write
    // cannot influence this cycle's branch.
    assign taken    = branch && cond_true && (state_q == RUN);
    assign pc_plus2 = pc_q + 16'd2;
    assign br_disp  = {{6{br_offset[8]}}, br_offset, 1'b0};

    always_comb begin
        next_pc = pc_plus2;
        if (taken) begin
            next_pc = branch_reg ? br_target : (pc_plus2 + br_disp);
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        flags_d = flags_q;
        cnt_d   = cnt_q;
        if (state_q == RUN && !stall) begin
            cnt_d = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
            if (hlt) begin
                state_d = HALTED;
            end else begin
                pc_d = next_pc;
                for (int i = 0; i < 3; i++) begin
                    if (flag_en[i]) flags_d[i] = flag_in[i];
                end
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples its pre-edge value regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= RUN;
            pc_q    <= RESET_PC;
            flags_q <= 3'b000;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            flags_q <= flags_d;
            cnt_q   <= cnt_d;
        end
    end

    assign pc          = pc_q;
    assign flags       = flags_q;
    assign halted      = (state_q == HALTED);
    assign instr_count = cnt_q;

endmodule
